// File: rtl/arc4_pkg.sv
// Shared RC4 encryptor/cracker definitions: FSM states, key layout, printable range and ct layout.
package arc4_pkg;

   typedef enum logic [4:0] {
      StIdle,
      StInit,
      StKsaRdi,
      StKsaWti,
      StKsaRdj,
      StKsaWtj,
      StKsaWri,
      StKsaWrj,
      StAccept,
      StPrgaRdi,
      StPrgaWti,
      StPrgaRdj,
      StPrgaWtj,
      StPrgaWri,
      StPrgaWrj,
      StPrgaRdk,
      StPrgaWtk,
      StPrgaWrct,
      StWrlen,
      StDone
   } arc4_state_e;

   localparam int unsigned KEY_BYTES   = 3;
   localparam logic [7:0]  PRINT_LO    = 8'h20;
   localparam logic [7:0]  PRINT_HI    = 8'h7E;
   localparam logic [7:0]  CT_LEN_ADDR = 8'h00;

   // Key bytes are consumed most-significant first.
   function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = key[23:16];
         2'd1:    b = key[15:8];
         default: b = key[7:0];
      endcase
      return b;
   endfunction

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= PRINT_LO) && (b <= PRINT_HI);
   endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// Host-side bundle of the encryptor: start/key, plaintext stream, ct memory write port and status.
interface arc4_encrypt_if;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic [7:0]  ct_addr;
   logic [7:0]  ct_wrdata;
   logic        ct_wren;
   logic        done;
   logic        err;

   modport master (
      output en, key, in_valid, in_data, in_last,
      input  rdy, in_ready, ct_addr, ct_wrdata, ct_wren, done, err
   );

   modport slave (
      input  en, key, in_valid, in_data, in_last,
      output rdy, in_ready, ct_addr, ct_wrdata, ct_wren, done, err
   );
endinterface

// File: rtl/s_mem.sv
// 256x8 single-port RAM with registered read (1-cycle latency); S-box store shared with the decryptor.
module s_mem (
   input  logic       clk,
   input  logic [7:0] addr,
   input  logic [7:0] wrdata,
   input  logic       wren,
   output logic [7:0] rddata
);

   logic [7:0] mem [256];

   // Read returns the old contents on a same-address write.
   always_ff @(posedge clk) begin
      if (wren) begin
         mem[addr] <= wrdata;
      end
      rddata <= mem[addr];
   end

endmodule

// File: rtl/arc4_encrypt.sv
// RC4 encryptor writing length-prefixed ciphertext (len at ct[0], bytes at ct[1..N]).
// Optional printable-input checking via ARC4_ENCRYPT_PRINTABLE_CHECK_EN.
module arc4_encrypt
   import arc4_pkg::*;
#(
   parameter int unsigned MAX_LEN = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   arc4_encrypt_if.slave  bus
);

   localparam logic [7:0] MaxLenB    = 8'(MAX_LEN);
   localparam logic [1:0] KeyIdxLast = 2'(KEY_BYTES - 1);

   arc4_state_e state_q, state_d;
   logic [23:0] key_q, key_d;
   logic [7:0]  i_q, i_d;
   logic [7:0]  j_q, j_d;
   logic [1:0]  kidx_q, kidx_d;
   logic [7:0]  si_q, si_d;
   logic [7:0]  sj_q, sj_d;
   logic [7:0]  byte_q, byte_d;
   logic        last_q, last_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  ct_addr_q, ct_addr_d;
   logic [7:0]  ct_wrdata_q, ct_wrdata_d;
   logic        ct_wren_q, ct_wren_d;
   logic        done_q, done_d;

   logic [7:0]  mem_addr;
   logic [7:0]  mem_wrdata;
   logic        mem_wren;
   logic [7:0]  mem_rddata;

   logic        start;
   logic        xfer;

   assign start = (state_q == StIdle) && bus.en;
   assign xfer  = (state_q == StAccept) && bus.in_valid;

   s_mem u_s_mem (
      .clk    (clk),
      .addr   (mem_addr),
      .wrdata (mem_wrdata),
      .wren   (mem_wren),
      .rddata (mem_rddata)
   );

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      i_d         = i_q;
      j_d         = j_q;
      kidx_d      = kidx_q;
      si_d        = si_q;
      sj_d        = sj_q;
      byte_d      = byte_q;
      last_d      = last_q;
      count_d     = count_q;
      ct_addr_d   = ct_addr_q;
      ct_wrdata_d = ct_wrdata_q;
      ct_wren_d   = 1'b0;
      done_d      = 1'b0;
      mem_addr    = i_q;
      mem_wrdata  = 8'h00;
      mem_wren    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               key_d   = bus.key;
               count_d = 8'h00;
               i_d     = 8'h00;
               j_d     = 8'h00;
               kidx_d  = 2'd0;
               state_d = StInit;
            end
         end
         StInit: begin
            mem_addr   = i_q;
            mem_wrdata = i_q;
            mem_wren   = 1'b1;
            i_d        = i_q + 8'd1;
            if (i_q == 8'hFF) begin
               state_d = StKsaRdi;
            end
         end
         StKsaRdi: begin
            mem_addr = i_q;
            state_d  = StKsaWti;
         end
         StKsaWti: begin
            si_d    = mem_rddata;
            j_d     = j_q + mem_rddata + key_byte(key_q, kidx_q);
            state_d = StKsaRdj;
         end
         StKsaRdj: begin
            mem_addr = j_q;
            state_d  = StKsaWtj;
         end
         StKsaWtj: begin
            sj_d    = mem_rddata;
            state_d = StKsaWri;
         end
         StKsaWri: begin
            mem_addr   = i_q;
            mem_wrdata = sj_q;
            mem_wren   = 1'b1;
            state_d    = StKsaWrj;
         end
         StKsaWrj: begin
            mem_addr   = j_q;
            mem_wrdata = si_q;
            mem_wren   = 1'b1;
            i_d        = i_q + 8'd1;
            kidx_d     = (kidx_q == KeyIdxLast) ? 2'd0 : kidx_q + 2'd1;
            // i wraps back to 0 on its own; PRGA also needs j = 0.
            if (i_q == 8'hFF) begin
               j_d     = 8'h00;
               state_d = StAccept;
            end else begin
               state_d = StKsaRdi;
            end
         end
         StAccept: begin
            if (xfer) begin
               byte_d  = bus.in_data;
               last_d  = bus.in_last;
               i_d     = i_q + 8'd1;
               state_d = StPrgaRdi;
            end
         end
         StPrgaRdi: begin
            mem_addr = i_q;
            state_d  = StPrgaWti;
         end
         StPrgaWti: begin
            si_d    = mem_rddata;
            j_d     = j_q + mem_rddata;
            state_d = StPrgaRdj;
         end
         StPrgaRdj: begin
            mem_addr = j_q;
            state_d  = StPrgaWtj;
         end
         StPrgaWtj: begin
            sj_d    = mem_rddata;
            state_d = StPrgaWri;
         end
         StPrgaWri: begin
            mem_addr   = i_q;
            mem_wrdata = sj_q;
            mem_wren   = 1'b1;
            state_d    = StPrgaWrj;
         end
         StPrgaWrj: begin
            mem_addr   = j_q;
            mem_wrdata = si_q;
            mem_wren   = 1'b1;
            state_d    = StPrgaRdk;
         end
         StPrgaRdk: begin
            mem_addr = si_q + sj_q;
            state_d  = StPrgaWtk;
         end
         StPrgaWtk: begin
            // ct outputs are registered, so the write is staged here and shows in StPrgaWrct.
            ct_wren_d   = 1'b1;
            ct_addr_d   = count_q + 8'd1;
            ct_wrdata_d = mem_rddata ^ byte_q;
            count_d     = count_q + 8'd1;
            state_d     = StPrgaWrct;
         end
         StPrgaWrct: begin
            if (last_q || (count_q == MaxLenB)) begin
               ct_wren_d   = 1'b1;
               ct_addr_d   = CT_LEN_ADDR;
               ct_wrdata_d = count_q;
               state_d     = StWrlen;
            end else begin
               state_d = StAccept;
            end
         end
         StWrlen: begin
            done_d  = 1'b1;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         key_q       <= 24'h000000;
         i_q         <= 8'h00;
         j_q         <= 8'h00;
         kidx_q      <= 2'd0;
         si_q        <= 8'h00;
         sj_q        <= 8'h00;
         byte_q      <= 8'h00;
         last_q      <= 1'b0;
         count_q     <= 8'h00;
         ct_addr_q   <= 8'h00;
         ct_wrdata_q <= 8'h00;
         ct_wren_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         i_q         <= i_d;
         j_q         <= j_d;
         kidx_q      <= kidx_d;
         si_q        <= si_d;
         sj_q        <= sj_d;
         byte_q      <= byte_d;
         last_q      <= last_d;
         count_q     <= count_d;
         ct_addr_q   <= ct_addr_d;
         ct_wrdata_q <= ct_wrdata_d;
         ct_wren_q   <= ct_wren_d;
         done_q      <= done_d;
      end
   end

`ifdef ARC4_ENCRYPT_PRINTABLE_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (start) begin
         err_d = 1'b0;
      end else if (xfer && !is_printable(bus.in_data)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.rdy       = (state_q == StIdle);
   assign bus.in_ready  = (state_q == StAccept);
   assign bus.ct_addr   = ct_addr_q;
   assign bus.ct_wrdata = ct_wrdata_q;
   assign bus.ct_wren   = ct_wren_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// Scoreboard bench for arc4_encrypt: stimulus pushes expected ct writes/done, a monitor pops and compares.
module tb_arc4_encrypt;

   localparam int MaxLen = 255;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic       is_done;
      logic [7:0] addr;
      logic [7:0] data;
   } sb_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   arc4_encrypt_if bus ();

   arc4_encrypt #(.MAX_LEN(MaxLen)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   sb_t exp_q[$];
   sb_t mon_e;
   int  n_vec = 0;
   int  n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic d, input logic [7:0] a, input logic [7:0] v);
      sb_t e;
      e.is_done = d;
      e.addr    = a;
      e.data    = v;
      exp_q.push_back(e);
   endtask

   // Plain RC4 over the whole message, straight from the algorithm definition.
   function automatic bq_t rc4_ct(input logic [23:0] k, input bq_t msg);
      int  s[256];
      int  kb[3];
      int  i, j, t;
      bq_t out;
      kb[0] = int'(k[23:16]);
      kb[1] = int'(k[15:8]);
      kb[2] = int'(k[7:0]);
      for (int n = 0; n < 256; n++) s[n] = n;
      j = 0;
      for (int n = 0; n < 256; n++) begin
         j = (j + s[n] + kb[n % 3]) % 256;
         t = s[n]; s[n] = s[j]; s[j] = t;
      end
      i = 0;
      j = 0;
      for (int n = 0; n < msg.size(); n++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         out.push_back(msg[n] ^ 8'(s[(s[i] + s[j]) % 256]));
      end
      return out;
   endfunction

   // Monitor: every ct write or done pulse must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (bus.ct_wren === 1'b1 || bus.done === 1'b1)) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out: wren=%0b done=%0b addr=%0h data=%0h, none expected (t=%0t)",
                     bus.ct_wren, bus.done, bus.ct_addr, bus.ct_wrdata, $time);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.is_done) begin
               check("done_pulse", 32'({bus.done, bus.ct_wren}), 32'(2'b10));
            end else begin
               check("ct_write", 32'({bus.done, bus.ct_wren, bus.ct_addr, bus.ct_wrdata}),
                     32'({1'b0, 1'b1, mon_e.addr, mon_e.data}));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input string name, input int bound);
      int n = 0;
      while (bus.rdy !== 1'b1 && n < bound) begin
         step();
         n++;
      end
      check(name, 32'(bus.rdy), 32'h1);
   endtask

   task automatic start(input logic [23:0] k);
      wait_rdy("rdy_before_start", 20);
      bus.en  = 1'b1;
      bus.key = k;
      step();
      bus.en  = 1'b0;
      bus.key = 24'($urandom);
      check("err_cleared_on_start", 32'(bus.err), 32'h0);
   endtask

   task automatic run_msg(input logic [23:0] k, input bq_t msg, input logic use_last,
                          input bq_t ct, input int bp, input int abort_n);
      int   nacc    = (msg.size() > MaxLen) ? MaxLen : msg.size();
      int   nfeed   = (abort_n > 0) ? abort_n : nacc;
      int   hold_at = (bp != 0) ? int'($urandom_range(0, nfeed - 1)) : -1;
      int   highs   = 0;
      int   n;
      logic exp_err = 1'b0;
`ifdef ARC4_ENCRYPT_PRINTABLE_CHECK_EN
      for (int b = 0; b < nfeed; b++) begin
         if (msg[b] < 8'h20 || msg[b] > 8'h7E) exp_err = 1'b1;
      end
`endif
      for (int b = 0; b < nfeed; b++) push_exp(1'b0, 8'(b + 1), ct[b]);
      if (abort_n == 0) begin
         push_exp(1'b0, 8'h00, 8'(nacc));
         push_exp(1'b1, 8'h00, 8'h00);
      end
      start(k);
      if (bp != 0) begin
         // A start request while busy must be ignored.
         repeat (100) step();
         bus.en  = 1'b1;
         bus.key = ~k;
         step();
         bus.en  = 1'b0;
      end
      for (int b = 0; b < nfeed; b++) begin
         n = 0;
         if (bp != 0) begin
            bus.in_valid = 1'b0;
            repeat ((b == hold_at) ? 50 : int'($urandom_range(0, 3))) step();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = msg[b];
         bus.in_last  = use_last && (b == msg.size() - 1);
         while (n < 4000) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            n++;
         end
         check("accept_in_time", 32'(n < 4000), 32'h1);
         if (n >= 4000) begin
            bus.in_valid = 1'b0;
            return;
         end
         step();
         bus.in_valid = 1'b0;
         bus.in_data  = 8'($urandom);
         bus.in_last  = 1'($urandom);
         @(negedge clk);
         check("ready_drop_after_xfer", 32'(bus.in_ready), 32'h0);
      end
      if (abort_n == 0 && msg.size() > nacc) begin
         bus.in_valid = 1'b1;
         bus.in_data  = msg[nacc];
         bus.in_last  = 1'b0;
         repeat (40) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) highs++;
         end
         check("trunc_no_ready", 32'(highs), 32'h0);
         bus.in_valid = 1'b0;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         step();
         n++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      if (abort_n == 0) begin
         wait_rdy("rdy_back", 5);
         check("err_flag", 32'(bus.err), 32'(exp_err));
      end
   endtask

   task automatic reset_mid();
      rst_n = 1'b0;
      step();
      check("rst_rdy", 32'(bus.rdy), 32'h1);
      check("rst_outs", 32'({bus.ct_wren, bus.done, bus.in_ready, bus.err, bus.ct_addr, bus.ct_wrdata}),
            32'h0);
      exp_q.delete();
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      repeat (30) step();
   endtask

   initial begin
      string pt_s  = "Plaintext";
      string err_s = "Hi\nthere";
      bq_t   pt, kct, m, c;
      logic [23:0] rk;
      int    len;

      foreach (pt_s[x]) pt.push_back(pt_s[x]);
      kct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

      rst_n        = 1'b0;
      bus.en       = 1'b0;
      bus.key      = 24'h0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
      repeat (3) step();
      check("reset_rdy", 32'(bus.rdy), 32'h1);
      check("reset_in_ready", 32'(bus.in_ready), 32'h0);
      check("reset_ct", 32'({bus.ct_wren, bus.ct_addr, bus.ct_wrdata}), 32'h0);
      check("reset_done_err", 32'({bus.done, bus.err}), 32'h0);
      rst_n = 1'b1;
      step();

      run_msg(24'h4B6579, pt, 1'b1, kct, 0, 0);
      run_msg(24'h4B6579, pt, 1'b1, kct, 1, 0);

      m.delete();
      for (int b = 0; b < 300; b++) m.push_back(8'($urandom));
      run_msg(24'h000018, m, 1'b0, rc4_ct(24'h000018, m), 0, 0);

      for (int r = 0; r < 3; r++) begin
         rk  = 24'($urandom);
         len = (r == 0) ? 40 : int'($urandom_range(1, 40));
         m.delete();
         for (int b = 0; b < len; b++) m.push_back(8'($urandom_range(32, 126)));
         run_msg(rk, m, 1'b1, rc4_ct(rk, m), r % 2, 0);
      end

      start(24'h4B6579);
      repeat (900) step();
      reset_mid();

      run_msg(24'h4B6579, pt, 1'b1, kct, 0, 3);
      reset_mid();

      run_msg(24'h4B6579, pt, 1'b1, kct, 0, 0);

      m.delete();
      foreach (err_s[x]) m.push_back(err_s[x]);
      rk = 24'h123456;
      run_msg(rk, m, 1'b1, rc4_ct(rk, m), 0, 0);
      run_msg(24'h4B6579, pt, 1'b1, kct, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
